// File: rtl/mips_leds_soc.sv
// Single-cycle MIPS-I subset SoC: core, unified word-addressed RAM and a
// memory-mapped 16-bit LED register. The RAM image is loaded externally while
// reset is held; reset only clears the PC and the LED register.

// Dual-read, single-write RAM array holding both program and data.
module mips_leds_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [31:0]      rdata_a,
  output logic [31:0]      rdata_b
);

  logic [31:0] mem [0:MEM_WORDS-1];

  // Store writes land on the rising edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// Folds 30-bit word addresses onto the RAM depth, so any depth works and
// out-of-range addresses alias back into the array.
module mips_leds_mem #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic [29:0] instr_word,
  input  logic [29:0] data_word,
  input  logic [31:0] write_data,
  input  logic        write_en,
  output logic [31:0] instr,
  output logic [31:0] read_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [IDX_W-1:0] instr_idx;
  logic [IDX_W-1:0] data_idx;

  assign instr_idx = IDX_W'(instr_word % 30'(MEM_WORDS));
  assign data_idx  = IDX_W'(data_word % 30'(MEM_WORDS));

  mips_leds_ram #(
    .MEM_WORDS(MEM_WORDS),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk    (clk),
    .we     (write_en),
    .waddr  (data_idx),
    .wdata  (write_data),
    .raddr_a(instr_idx),
    .raddr_b(data_idx),
    .rdata_a(instr),
    .rdata_b(read_data)
  );

endmodule

// Memory-mapped LED output register.
module mips_leds_ledreg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] o_leds
);

  // Cleared by reset, otherwise loaded by any store that hits the LED window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_leds <= 16'h0000;
    end else if (we) begin
      o_leds <= wdata;
    end
  end

endmodule

// 32x32 register file; r0 is never written and always reads as zero.
module mips_leds_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [0:31];

  // Write port; a write aimed at r0 is simply dropped.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// Top level: fetch, decode, execute and write back all within one clock.
module mips_leds_soc #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] LED_ADDR  = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  output logic [15:0] o_leds
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0a,
    OP_SLTIU = 6'h0b,
    OP_ANDI  = 6'h0c,
    OP_ORI   = 6'h0d,
    OP_XORI  = 6'h0e,
    OP_LUI   = 6'h0f,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2a,
    FN_SLTU = 6'h2b
  } funct_t;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] instr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        store;

  logic [31:0] data_addr;
  logic [31:0] ram_rdata;
  logic [31:0] load_data;
  logic        led_hit;
  logic        ram_we;
  logic        led_we;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Loads and stores decode on bit 31 alone: the whole upper half of the
  // address space mirrors the LED register.
  assign data_addr = rs_val + imm_sext;
  assign led_hit   = data_addr[31] & LED_ADDR[31];
  assign load_data = led_hit ? {16'h0000, o_leds} : ram_rdata;

  // No architectural write is allowed while reset is held, so the image the
  // bench loads during reset cannot be disturbed by whatever sits at PC 0.
  assign ram_we = store & ~led_hit & i_arst_n;
  assign led_we = store & led_hit & i_arst_n;

  // Decode and execute; anything unrecognised falls through as a NOP.
  always_comb begin
    next_pc  = pc_plus4;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;
    store    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rf_waddr = rd;
        rf_we    = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: rf_wdata = rs_val + rt_val;
          FN_SUB, FN_SUBU: rf_wdata = rs_val - rt_val;
          FN_AND:          rf_wdata = rs_val & rt_val;
          FN_OR:           rf_wdata = rs_val | rt_val;
          FN_XOR:          rf_wdata = rs_val ^ rt_val;
          FN_NOR:          rf_wdata = ~(rs_val | rt_val);
          FN_SLT:          rf_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU:         rf_wdata = {31'd0, rs_val < rt_val};
          FN_SLL:          rf_wdata = rt_val << shamt;
          FN_SRL:          rf_wdata = rt_val >> shamt;
          FN_JR: begin
            rf_we   = 1'b0;
            next_pc = rs_val;
          end
          default:         rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        rf_we    = 1'b1;
        rf_wdata = rs_val + imm_sext;
      end
      OP_SLTI: begin
        rf_we    = 1'b1;
        rf_wdata = {31'd0, $signed(rs_val) < $signed(imm_sext)};
      end
      OP_SLTIU: begin
        rf_we    = 1'b1;
        rf_wdata = {31'd0, rs_val < imm_sext};
      end
      OP_ANDI: begin
        rf_we    = 1'b1;
        rf_wdata = rs_val & imm_zext;
      end
      OP_ORI: begin
        rf_we    = 1'b1;
        rf_wdata = rs_val | imm_zext;
      end
      OP_XORI: begin
        rf_we    = 1'b1;
        rf_wdata = rs_val ^ imm_zext;
      end
      OP_LUI: begin
        rf_we    = 1'b1;
        rf_wdata = {imm, 16'h0000};
      end
      OP_LW: begin
        rf_we    = 1'b1;
        rf_wdata = load_data;
      end
      OP_SW: begin
        store = 1'b1;
      end
      OP_BEQ: begin
        if (rs_val == rt_val) next_pc = branch_target;
      end
      OP_BNE: begin
        if (rs_val != rt_val) next_pc = branch_target;
      end
      OP_J: begin
        next_pc = jump_target;
      end
      OP_JAL: begin
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_plus4;
        next_pc  = jump_target;
      end
      default: begin
        next_pc = pc_plus4;
      end
    endcase
  end

  // Program counter: restart at 0 on reset, otherwise follow the decoder.
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      pc <= 32'd0;
    end else begin
      pc <= next_pc;
    end
  end

  mips_leds_regfile u_regfile (
    .clk    (i_clk),
    .we     (rf_we & i_arst_n),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(rs),
    .raddr_b(rt),
    .rdata_a(rs_val),
    .rdata_b(rt_val)
  );

  mips_leds_mem #(
    .MEM_WORDS(MEM_WORDS)
  ) mem (
    .clk       (i_clk),
    .instr_word(pc[31:2]),
    .data_word (data_addr[31:2]),
    .write_data(rt_val),
    .write_en  (ram_we),
    .instr     (instr),
    .read_data (ram_rdata)
  );

  mips_leds_ledreg u_leds (
    .clk   (i_clk),
    .rst_n (i_arst_n),
    .we    (led_we),
    .wdata (rt_val[15:0]),
    .o_leds(o_leds)
  );

endmodule

// File: tb/tb_mips_leds_soc.sv
// Directed bench for mips_leds_soc: hand-assembled programs are loaded into
// the RAM during reset and results are read back from agreed RAM words.
module tb_mips_leds_soc;

  logic        clk;
  logic        rst_n;
  logic [15:0] leds;

  int vectors;
  int miscompares;

  logic [31:0] prog [$];

  mips_leds_soc #(
    .MEM_WORDS(1024),
    .LED_ADDR (32'h8000_0000)
  ) dut (
    .i_clk   (clk),
    .i_arst_n(rst_n),
    .o_leds  (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                       input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_op(input int op, input int rs, input int rt,
                                       input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int op, input int idx);
    return {6'(op), 26'(idx)};
  endfunction

  // Hold reset, wipe RAM, load prog, then release at a falling edge.
  task automatic start_program();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.mem.u_mem.mem[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) dut.mem.u_mem.mem[i] = prog[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for the completion flag in word 320, bounded.
  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (dut.mem.u_mem.mem[320] === 32'd1) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL %s_done: flag=%h required 00000001 within 600 clocks",
               name, dut.mem.u_mem.mem[320]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (leds !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_leds: got %h required 0000", leds);
    end
    vectors++;
    if (dut.pc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_pc: got %h required 00000000", dut.pc);
    end
  endtask

  // Sum 1..6 into word 321, LEDs <= 0x30, then raise the flag.
  task automatic test_program();
    prog = {
      i_op(6'h09, 0, 1, 0),          // 00 addiu r1,r0,0
      i_op(6'h09, 0, 2, 6),          // 04 addiu r2,r0,6
      r_op(1, 2, 1, 0, 6'h21),       // 08 addu r1,r1,r2
      i_op(6'h09, 2, 2, -1),         // 0c addiu r2,r2,-1
      i_op(6'h05, 2, 0, -3),         // 10 bne r2,r0,loop
      i_op(6'h0f, 0, 3, 16'h8000),   // 14 lui r3,0x8000
      i_op(6'h0d, 0, 4, 16'h0030),   // 18 ori r4,r0,0x30
      i_op(6'h2b, 3, 4, 0),          // 1c sw r4,0(r3)
      i_op(6'h2b, 0, 1, 16'h0504),   // 20 sw r1,0x504(r0)
      i_op(6'h09, 0, 5, 1),          // 24 addiu r5,r0,1
      i_op(6'h2b, 0, 5, 16'h0500),   // 28 sw r5,0x500(r0)
      j_op(6'h02, 11)                // 2c j self
    };
    start_program();
    wait_done("program");
    vectors++;
    if (dut.mem.u_mem.mem[321] !== 32'd21) begin
      miscompares++;
      $display("[TB] FAIL program_result: got %0d required 21", dut.mem.u_mem.mem[321]);
    end
    vectors++;
    if (leds !== 16'h0030) begin
      miscompares++;
      $display("[TB] FAIL program_leds: got %h required 0030", leds);
    end
  endtask

  // Reset the running program for 3 cycles, then let it rerun from PC 0.
  task automatic test_reset_mid_run();
    @(negedge clk);
    rst_n = 1'b0;
    dut.mem.u_mem.mem[320] = 32'd0;
    dut.mem.u_mem.mem[321] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (leds !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_leds: got %h required 0000", leds);
    end
    vectors++;
    if (dut.pc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_pc: got %h required 00000000", dut.pc);
    end
    rst_n = 1'b1;
    wait_done("rerun");
    vectors++;
    if (dut.mem.u_mem.mem[321] !== 32'd21) begin
      miscompares++;
      $display("[TB] FAIL rerun_result: got %0d required 21", dut.mem.u_mem.mem[321]);
    end
    vectors++;
    if (leds !== 16'h0030) begin
      miscompares++;
      $display("[TB] FAIL rerun_leds: got %h required 0030", leds);
    end
  endtask

  task automatic test_compare();
    logic [31:0] expv [5];
    expv = '{32'd1, 32'd0, 32'd1, 32'd1, 32'd1};
    prog = {
      i_op(6'h09, 0, 1, -1),         // 00 addiu r1,r0,-1
      r_op(0, 1, 2, 0, 6'h2b),       // 04 sltu r2,r0,r1
      r_op(0, 1, 3, 0, 6'h2a),       // 08 slt  r3,r0,r1
      r_op(1, 0, 4, 0, 6'h2a),       // 0c slt  r4,r1,r0
      i_op(6'h0b, 0, 5, -1),         // 10 sltiu r5,r0,-1
      i_op(6'h0a, 1, 6, 0),          // 14 slti r6,r1,0
      i_op(6'h2b, 0, 2, 16'h0600),   // 18 sw r2,0x600
      i_op(6'h2b, 0, 3, 16'h0604),   // 1c sw r3,0x604
      i_op(6'h2b, 0, 4, 16'h0608),   // 20 sw r4,0x608
      i_op(6'h2b, 0, 5, 16'h060c),   // 24 sw r5,0x60c
      i_op(6'h2b, 0, 6, 16'h0610),   // 28 sw r6,0x610
      i_op(6'h09, 0, 7, 1),          // 2c addiu r7,r0,1
      i_op(6'h2b, 0, 7, 16'h0500),   // 30 sw r7,0x500
      j_op(6'h02, 13)                // 34 j self
    };
    start_program();
    wait_done("compare");
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dut.mem.u_mem.mem[384+i] !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL compare_%0d: got %h required %h", i,
                 dut.mem.u_mem.mem[384+i], expv[i]);
      end
    end
  endtask

  task automatic test_led_map();
    prog = {
      i_op(6'h0f, 0, 1, 16'h8000),   // 00 lui r1,0x8000
      i_op(6'h0d, 0, 2, 16'h1234),   // 04 ori r2,r0,0x1234
      i_op(6'h2b, 1, 2, 0),          // 08 sw r2,0(r1)
      i_op(6'h23, 1, 3, 0),          // 0c lw r3,0(r1)
      i_op(6'h2b, 0, 3, 16'h0600),   // 10 sw r3,0x600
      i_op(6'h0f, 0, 4, 16'habcd),   // 14 lui r4,0xabcd
      i_op(6'h0d, 4, 4, 16'h5678),   // 18 ori r4,r4,0x5678
      i_op(6'h2b, 1, 4, 4),          // 1c sw r4,4(r1)
      i_op(6'h23, 1, 5, 8),          // 20 lw r5,8(r1)
      i_op(6'h2b, 0, 5, 16'h0604),   // 24 sw r5,0x604
      i_op(6'h09, 0, 6, 1),          // 28 addiu r6,r0,1
      i_op(6'h2b, 0, 6, 16'h0500),   // 2c sw r6,0x500
      j_op(6'h02, 12)                // 30 j self
    };
    start_program();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (leds !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL led_first_store: got %h required 1234", leds);
    end
    wait_done("led");
    vectors++;
    if (dut.mem.u_mem.mem[384] !== 32'h0000_1234) begin
      miscompares++;
      $display("[TB] FAIL led_readback: got %h required 00001234", dut.mem.u_mem.mem[384]);
    end
    vectors++;
    if (dut.mem.u_mem.mem[385] !== 32'h0000_5678) begin
      miscompares++;
      $display("[TB] FAIL led_zext: got %h required 00005678", dut.mem.u_mem.mem[385]);
    end
    vectors++;
    if (leds !== 16'h5678) begin
      miscompares++;
      $display("[TB] FAIL led_final: got %h required 5678", leds);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dut.mem.u_mem.mem[i] !== prog[i]) begin
        miscompares++;
        $display("[TB] FAIL led_ram_untouched_%0d: got %h required %h", i,
                 dut.mem.u_mem.mem[i], prog[i]);
      end
    end
  endtask

  task automatic test_control_flow();
    logic [31:0] expv [8];
    expv = '{32'h0000_001c, 32'd4, 32'd4, 32'd0, 32'h0000_01dc,
             32'hffff_ff89, 32'h0000_f00f, 32'd4};
    prog = {
      i_op(6'h09, 0, 1, 0),          // 00 addiu r1,r0,0
      i_op(6'h04, 0, 0, 2),          // 04 beq r0,r0,+2 -> 10
      i_op(6'h09, 1, 1, 1),          // 08 skipped
      i_op(6'h09, 1, 1, 2),          // 0c skipped
      i_op(6'h05, 0, 0, 1),          // 10 bne r0,r0 falls through
      i_op(6'h09, 1, 1, 4),          // 14 addiu r1,r1,4
      j_op(6'h03, 9),                // 18 jal 0x24
      i_op(6'h09, 1, 1, 8),          // 1c skipped
      i_op(6'h09, 1, 1, 16),         // 20 skipped
      i_op(6'h2b, 0, 31, 16'h0600),  // 24 sw r31,0x600
      i_op(6'h2b, 0, 1, 16'h0604),   // 28 sw r1,0x604
      i_op(6'h09, 0, 2, 16'h003c),   // 2c addiu r2,r0,0x3c
      r_op(2, 0, 0, 0, 6'h08),       // 30 jr r2
      i_op(6'h09, 1, 1, 32),         // 34 skipped
      i_op(6'h09, 1, 1, 64),         // 38 skipped
      i_op(6'h2b, 0, 1, 16'h0608),   // 3c sw r1,0x608
      r_op(1, 1, 0, 0, 6'h21),       // 40 addu r0,r1,r1
      i_op(6'h2b, 0, 0, 16'h060c),   // 44 sw r0,0x60c
      i_op(6'h0d, 0, 6, 16'h0077),   // 48 ori r6,r0,0x77
      i_op(6'h2b, 0, 6, 16'h1000),   // 4c sw r6,0x1000 -> word 0
      r_op(0, 6, 7, 4, 6'h00),       // 50 sll r7,r6,4
      r_op(0, 7, 8, 2, 6'h02),       // 54 srl r8,r7,2
      i_op(6'h2b, 0, 8, 16'h0610),   // 58 sw r8,0x610
      r_op(0, 6, 9, 0, 6'h23),       // 5c subu r9,r0,r6
      i_op(6'h2b, 0, 9, 16'h0614),   // 60 sw r9,0x614
      r_op(0, 0, 10, 0, 6'h27),      // 64 nor r10,r0,r0
      i_op(6'h0c, 10, 11, 16'hf0f0), // 68 andi r11,r10,0xf0f0
      i_op(6'h0e, 11, 12, 16'h00ff), // 6c xori r12,r11,0x00ff
      i_op(6'h2b, 0, 12, 16'h0618),  // 70 sw r12,0x618
      r_op(0, 6, 1, 0, 6'h3f),       // 74 unsupported funct
      i_op(6'h3f, 0, 1, 5),          // 78 unsupported opcode
      i_op(6'h2b, 0, 1, 16'h061c),   // 7c sw r1,0x61c
      i_op(6'h09, 0, 13, 1),         // 80 addiu r13,r0,1
      i_op(6'h2b, 0, 13, 16'h0500),  // 84 sw r13,0x500
      j_op(6'h02, 34)                // 88 j self
    };
    start_program();
    wait_done("flow");
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dut.mem.u_mem.mem[384+i] !== expv[i]) begin
        miscompares++;
        $display("[TB] FAIL flow_%0d: got %h required %h", i,
                 dut.mem.u_mem.mem[384+i], expv[i]);
      end
    end
    vectors++;
    if (dut.mem.u_mem.mem[0] !== 32'h0000_0077) begin
      miscompares++;
      $display("[TB] FAIL flow_alias_word0: got %h required 00000077", dut.mem.u_mem.mem[0]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    test_reset();
    test_program();
    test_reset_mid_run();
    test_compare();
    test_led_map();
    test_control_flow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
